// File: rtl/sync_fifo_pkg.sv
// Shared constants, output-stage state encoding and level-width helpers for
// sync_fifo_ctrl and the parents that instantiate it.
package sync_fifo_pkg;

  localparam int unsigned AE_LEVEL_DEFAULT = 4;
  localparam int unsigned AF_MARGIN        = 4;

  typedef enum logic [1:0] {
    OS_EMPTY = 2'd0,
    OS_ONE   = 2'd1,
    OS_TWO   = 2'd2
  } os_state_e;

  // Level counts RAM words plus one in-flight read plus two stage entries,
  // so it needs two bits beyond the RAM address.
  function automatic int unsigned level_width(input int unsigned aw);
    return aw + 2;
  endfunction

  function automatic int unsigned af_level_default(input int unsigned aw);
    return (1 << aw) - AF_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry skid buffer at the FIFO read side; entry 0 is always the head
// word presented downstream, so out_data_o only moves on a pop or first fill.
module fifo_out_stage
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            count_o
);

  os_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic                  pop;

  assign out_valid_o = (state_q != OS_EMPTY);
  assign out_data_o  = e0_q;
  assign count_o     = state_q;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OS_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    unique case (state_q)
      OS_EMPTY: begin
        if (in_valid_i) begin
          e0_d    = in_data_i;
          state_d = OS_ONE;
        end
      end
      OS_ONE: begin
        unique case ({in_valid_i, pop})
          2'b10: begin
            e1_d    = in_data_i;
            state_d = OS_TWO;
          end
          2'b01: state_d = OS_EMPTY;
          2'b11: e0_d = in_data_i;
          default: ;
        endcase
      end
      OS_TWO: begin
        // The read issue rule keeps a push away from a full stage that is
        // not also popping, so only pop and pop+push are handled here.
        if (pop) begin
          e0_d = e1_q;
          if (in_valid_i) e1_d = in_data_i;
          else            state_d = OS_ONE;
        end
      end
      default: state_d = OS_EMPTY;
    endcase
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external 1-cycle-latency RAM, with a
// two-entry output skid buffer. Define SYNC_FIFO_CTRL_HWM_EN for the high-water mark.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AF_LEVEL   = af_level_default(ADDR_WIDTH),
  parameter int unsigned AE_LEVEL   = AE_LEVEL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_wr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_rd,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH+1:0] hwm,
  input  logic                  hwm_clr
);

  localparam int unsigned LW = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH:0] ram_cnt;
  logic                ram_empty, ram_full;
  logic                wr_fire, rd_fire, pop;
  logic [1:0]          stage_cnt;
  logic [2:0]          occ;

  assign ram_empty = (wptr_q == rptr_q);
  assign ram_full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                     (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

  assign s_ready = rst_n && !ram_full;
  assign wr_fire = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Counting the word leaving this cycle keeps stage + in-flight read at one
  // each in steady streaming, which is what sustains one word per cycle.
  assign occ     = {1'b0, stage_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_fire = !ram_empty && (occ < 3'd2);

  assign ram_wr    = wr_fire;
  assign ram_waddr = wptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata = s_data;
  assign ram_rd    = rd_fire;
  assign ram_raddr = rptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_pend_d = rd_fire;
    if (wr_fire) wptr_d = wptr_q + 1'b1;
    if (rd_fire) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (rd_pend_q),
    .in_data_i   (ram_rdata),
    .out_data_o  (m_data),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .count_o     (stage_cnt)
  );

  assign ram_cnt      = wptr_q - rptr_q;
  assign level        = {1'b0, ram_cnt} + LW'(rd_pend_q) + LW'(stage_cnt);
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign almost_empty = (level <= LW'(AE_LEVEL));

`ifdef SYNC_FIFO_CTRL_HWM_EN
  logic [LW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr)            hwm_d = level;
    else if (level > hwm_q) hwm_d = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = hwm_clr;
  assign hwm            = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and randomized bench for sync_fifo_ctrl (ADDR_WIDTH=2) against a
// queue-based reference model and a single-cycle RAM model.
module tb_sync_fifo_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AF = 4;
  localparam int unsigned AE = 1;
`ifdef SYNC_FIFO_CTRL_HWM_EN
  localparam int unsigned HWM_PEAK = 5;
`else
  localparam int unsigned HWM_PEAK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW+1:0] level;
  logic          almost_full, almost_empty;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          ram_wr, ram_rd;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [AW+1:0] hwm;
  logic          hwm_clr = 1'b0;

  logic [DW-1:0] mem [4];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] q[$];
  int unsigned   hwm_m = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  logic          smp_accept, smp_pop, smp_m_valid, smp_s_ready, smp_ram_rd, smp_af;
  logic [DW-1:0] smp_m_data;
  logic [AW+1:0] smp_level, smp_hwm;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_waddr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_raddr];
  end

  sync_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ram_waddr    (ram_waddr),
    .ram_wr       (ram_wr),
    .ram_wdata    (ram_wdata),
    .ram_raddr    (ram_raddr),
    .ram_rd       (ram_rd),
    .ram_rdata    (ram_rdata),
    .hwm          (hwm),
    .hwm_clr      (hwm_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample and check at the falling edge,
  // then advance the reference model at the rising edge.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
    int unsigned sz;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk);
    sz          = q.size();
    smp_accept  = s_valid && s_ready;
    smp_pop     = m_valid && m_ready;
    smp_m_valid = m_valid;
    smp_m_data  = m_data;
    smp_s_ready = s_ready;
    smp_ram_rd  = ram_rd;
    smp_af      = almost_full;
    smp_level   = level;
    smp_hwm     = hwm;
    check("level", 32'(level), sz);
    check("almost_full", 32'(almost_full), 32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    if (sz < 4) check("s_ready_room", 32'(s_ready), 1);
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 1);
      check("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (smp_pop) begin
      if (sz == 0) check("pop_when_empty", 32'(m_valid), 0);
      else         check("m_data", 32'(m_data), 32'(q[0]));
    end
    check("hwm", 32'(hwm), hwm_m);
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge clk);
`ifdef SYNC_FIFO_CTRL_HWM_EN
    if (hwm_clr)         hwm_m = sz;
    else if (sz > hwm_m) hwm_m = sz;
`endif
    if (smp_pop && sz != 0) void'(q.pop_front());
    if (smp_accept) q.push_back(sd);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b1;
    s_data  = 8'h55;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    #2;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_almost_empty", 32'(almost_empty), 1);
    check("rst_ram_wr", 32'(ram_wr), 0);
    check("rst_ram_rd", 32'(ram_rd), 0);
    check("rst_hwm", 32'(hwm), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    hwm_m      = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    int unsigned idx, nacc, npop, sent, consumed;
    int          first_pop, last_pop;

    do_reset();
    cycle(1'b0, '0, 1'b1);
    check("s_ready_after_reset", 32'(smp_s_ready), 1);

    // Single word latency through an empty FIFO.
    cycle(1'b1, 8'hA1, 1'b1);
    check("lat_accept", 32'(smp_accept), 1);
    cycle(1'b0, '0, 1'b1);
    check("lat_c1_mvalid", 32'(smp_m_valid), 0);
    cycle(1'b0, '0, 1'b1);
    check("lat_c2_mvalid", 32'(smp_m_valid), 0);
    cycle(1'b0, '0, 1'b1);
    check("lat_c3_mvalid", 32'(smp_m_valid), 1);
    check("lat_c3_mdata", 32'(smp_m_data), 32'h A1);
    cycle(1'b0, '0, 1'b1);
    check("lat_c4_level", 32'(smp_level), 0);

    // Fill with the consumer stalled: RAM plus both stage entries.
    idx = 0;
    repeat (10) begin
      cycle(1'b1, 8'(idx), 1'b0);
      if (smp_accept) idx++;
    end
    check("fill_accepted", idx, 6);
    cycle(1'b0, '0, 1'b0);
    check("fill_s_ready", 32'(smp_s_ready), 0);
    check("fill_level", 32'(smp_level), 6);
    check("fill_almost_full", 32'(smp_af), 1);
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("fill_drained_level", 32'(smp_level), 0);

    // Back-to-back streaming across several pointer wraps.
    nacc = 0; npop = 0; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 30; c++) begin
      cycle(c < 20, 8'(c + 8'h40), 1'b1);
      if (smp_accept) nacc++;
      if (smp_pop) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        npop++;
      end
    end
    check("stream_accepted", nacc, 20);
    check("stream_pops", npop, 20);
    check("stream_first", 32'(first_pop), 3);
    check("stream_span", 32'(last_pop - first_pop), 19);

    // Random producer and consumer stalls.
    sent = 0; consumed = 0;
    for (int n = 0; n < 3000 && consumed < 100; n++) begin
      cycle((sent < 100) && ($urandom_range(3, 0) != 0), 8'($urandom), 1'($urandom_range(1, 0)));
      if (smp_accept) sent++;
      if (smp_pop) consumed++;
    end
    check("rand_consumed", consumed, 100);
    cycle(1'b0, '0, 1'b1);
    check("rand_level", 32'(smp_level), 0);

    // Reset while a RAM read is in flight.
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    check("inflight_rd", 32'(smp_ram_rd), 1);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2;
    check("pre_reset_level", 32'(level), 3);
    do_reset();
    repeat (4) begin
      cycle(1'b0, '0, 1'b1);
      check("no_stale_mvalid", 32'(smp_m_valid), 0);
    end

    // High-water mark capture and clear.
    repeat (5) cycle(1'b1, 8'($urandom), 1'b0);
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("hwm_peak", 32'(smp_hwm), HWM_PEAK);
    hwm_clr = 1'b1;
    cycle(1'b0, '0, 1'b1);
    hwm_clr = 1'b0;
    cycle(1'b0, '0, 1'b1);
    check("hwm_cleared", 32'(smp_hwm), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: RAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ADDR_WIDTH-4: almost_full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty threshold.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all ports synchronous to it
- rst_n  in  1  asynchronous active-low reset
- s_data  in  DATA_WIDTH  write data
- s_valid  in  1  write request
- s_ready  out  1  write accepted when s_valid && s_ready
- m_data  out  DATA_WIDTH  read data
- m_valid  out  1  m_data valid
- m_ready  in  1  word consumed when m_valid && m_ready
- level  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output stage)
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- ram_waddr  out  ADDR_WIDTH  RAM write address
- ram_wr  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_rd  out  1  RAM read enable
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_rd
- hwm  out  ADDR_WIDTH+2  high-water mark of level
- hwm_clr  in  1  clear hwm

Function
REQ-006 SHALL use ADDR_WIDTH+1-bit wptr/rptr; RAM empty when equal; RAM full when MSBs differ and lower bits equal.
REQ-007 SHALL drive s_ready = !ram_full, registered-state-derived; no combinational path from s_valid or m_ready.
REQ-008 On accept SHALL drive ram_wr=1, ram_waddr=wptr[ADDR_WIDTH-1:0], ram_wdata=s_data combinationally in the same cycle, and increment wptr at the edge.
REQ-009 SHALL issue ram_rd=1, ram_raddr=rptr[ADDR_WIDTH-1:0] and increment rptr when RAM non-empty and (output-stage entries + rd_pend) < 2.
REQ-010 SHALL track the in-flight read with an internal reset register rd_pend and SHALL capture ram_rdata into the output stage on the cycle after ram_rd; no RAM valid output is used.
REQ-011 Output stage SHALL be a 2-entry skid buffer presenting the oldest entry on m_data/m_valid; full throughput of 1 word/cycle SHALL be sustained with m_ready held high.
REQ-012 Latency: word accepted in cycle N SHALL appear with m_valid=1 in cycle N+3 when FIFO was empty.
REQ-013 Simultaneous accept and consume SHALL leave level unchanged; level SHALL never exceed 2**ADDR_WIDTH+2.
REQ-014 Pointers SHALL wrap modulo 2**(ADDR_WIDTH+1) without loss or duplication.
REQ-015 m_data SHALL hold stable while m_valid && !m_ready.

Reset
REQ-016 rst_n low SHALL asynchronously clear wptr, rptr, rd_pend, output stage and hwm; outputs: s_ready=0 during reset, m_valid=0, level=0, almost_full=0, almost_empty=1, ram_wr=0, ram_rd=0.
REQ-017 s_ready SHALL be 1 on the first cycle after rst_n deasserts; reset mid-operation SHALL discard all contents including any in-flight read.

Configuration
REQ-018 With SYNC_FIFO_CTRL_HWM_EN defined, hwm SHALL register max(level) seen since reset or last hwm_clr; hwm_clr SHALL set hwm to current level next cycle.
REQ-019 Without SYNC_FIFO_CTRL_HWM_EN, hwm SHALL be tied to 0 and hwm_clr ignored; ports remain present.

Structure
REQ-020 Package sync_fifo_pkg SHALL hold level-width function and threshold constants shared with parents.
REQ-021 Skid buffer SHALL be sub-module fifo_out_stage; the RAM SHALL be instantiated by the parent, not inside this block.

Verification (ADDR_WIDTH=2, AF_LEVEL=4, AE_LEVEL=1, single-cycle RAM model)
REQ-022 Write 0xA1 into empty FIFO at cycle 0, m_ready=1 -> m_valid=1, m_data=0xA1 at cycle 3, level back to 0 at cycle 4.
REQ-023 m_ready=0, s_valid held high with 0..7 -> 6 accepted (4 RAM + 2 stage), s_ready=0, level=6, almost_full=1.
REQ-024 Stream 20 words with s_valid=m_ready=1 -> 1 word/cycle out, order 0..19, pointers wrap cleanly.
REQ-025 Random m_ready stalls over 100 words -> m_data stable during stalls, no loss or duplicates.
REQ-026 rst_n pulsed low with level=3 and ram_rd in flight -> m_valid=0, level=0 next cycle; no stale word emitted.
REQ-027 With SYNC_FIFO_CTRL_HWM_EN: fill to 5, drain, hwm=5; pulse hwm_clr at level 0 -> hwm=0.
